// File: rtl/dp_ram_tx.sv
// HPS-writable 32-bit RAM with an Avalon control/status port.
// A start command streams ram[0..count-1] out on a valid/ready interface.
module dp_ram_tx #(
    parameter int ID         = 2,
    parameter int DEPTH_LOG2 = 11
) (
    input  logic        avalon_clock,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [2:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] data_arith,
    output logic        valid_arith,
    input  logic        ready_arith,
    output logic        done_arith
);

    localparam int AW = DEPTH_LOG2;
    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM,
        FINISH
    } state_t;

    state_t         state;
    logic [31:0]    ram [0:(1<<AW)-1];
    logic [AW-1:0]  wr_ptr;
    logic [AW:0]    count;
    logic [AW:0]    rd_idx;
    logic [AW:0]    xfer_cnt;
    logic           done;
    logic           wr_err;
    logic           busy;
    logic           rq_v;
    logic           sk_v;
    logic [31:0]    ram_q;
    logic [31:0]    sk_d;
    logic [31:0]    rd_mux;

    logic           wr_ok;
    logic           start;
    logic           xfer;
    logic [1:0]     occ;
    logic           room;
    logic           fetch;
    logic           issue;
    logic [AW-1:0]  raddr;

    assign busy       = (state != IDLE);
    assign done_arith = done;

    assign wr_ok = write && (address == 3'd0) && !busy;
    assign start = write && (address == 3'd4) && writedata[0]
                   && (state == IDLE);
    assign xfer  = valid_arith & ready_arith;

    // Words in flight: output reg + skid reg + RAM read landing.
    assign occ   = {1'b0, valid_arith} + {1'b0, sk_v} + {1'b0, rq_v};
    assign room  = (occ - {1'b0, xfer}) < 2'd2;
    assign fetch = ((state == PRIME) || (state == STREAM))
                   && (rd_idx < count) && room;
    assign issue = (start && (count != '0)) || fetch;
    assign raddr = start ? '0 : rd_idx[AW-1:0];

    always_comb begin
        rd_mux = '0;
        case (address)
            3'd1:    rd_mux = 32'(wr_ptr);
            3'd2:    rd_mux = 32'(count);
            3'd3:    rd_mux = 32'(ID);
            3'd4:    rd_mux = {29'b0, wr_err, done, busy};
            default: rd_mux = '0;
        endcase
    end

    // RAM array is never reset; contents survive reset.
    always_ff @(posedge avalon_clock) begin
        if (wr_ok)
            ram[wr_ptr] <= writedata;
        if (issue)
            ram_q <= ram[raddr];
    end

    always_ff @(posedge avalon_clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            count       <= '0;
            rd_idx      <= '0;
            xfer_cnt    <= '0;
            done        <= 1'b0;
            wr_err      <= 1'b0;
            rq_v        <= 1'b0;
            sk_v        <= 1'b0;
            sk_d        <= '0;
            valid_arith <= 1'b0;
            data_arith  <= '0;
            readdata    <= '0;
        end else begin
            if (write) begin
                case (address)
                    3'd0: begin
                        if (busy)
                            wr_err <= 1'b1;
                        else
                            wr_ptr <= wr_ptr + 1'b1;
                    end
                    3'd1: wr_ptr <= writedata[AW-1:0];
                    3'd2: count <= (writedata > 32'(FULL)) ?
                                   FULL : writedata[AW:0];
                    3'd4: begin
                        if (writedata[1]) begin
                            done   <= 1'b0;
                            wr_err <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end

            if (read)
                readdata <= rd_mux;

            rq_v <= issue;
            if (issue)
                rd_idx <= start ? {{AW{1'b0}}, 1'b1} : rd_idx + 1'b1;

            // Output stage with one-word skid so reads never stall.
            if (xfer) begin
                if (sk_v) begin
                    data_arith <= sk_d;
                    sk_v       <= 1'b0;
                end else if (rq_v) begin
                    data_arith <= ram_q;
                end else begin
                    valid_arith <= 1'b0;
                end
            end else if (!valid_arith) begin
                if (rq_v) begin
                    data_arith  <= ram_q;
                    valid_arith <= 1'b1;
                end
            end else if (rq_v) begin
                sk_d <= ram_q;
                sk_v <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        done     <= 1'b0;
                        xfer_cnt <= '0;
                        state    <= (count == '0) ? FINISH : PRIME;
                    end
                end
                PRIME: begin
                    if (rq_v)
                        state <= STREAM;
                end
                STREAM: begin
                    if (xfer) begin
                        xfer_cnt <= xfer_cnt + 1'b1;
                        if (xfer_cnt + 1'b1 == count)
                            state <= FINISH;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dp_ram_tx.sv
// Directed bench for dp_ram_tx: Avalon register access, streaming
// timing, back-pressure, error status and reset behaviour.
module tb_dp_ram_tx;

    logic        avalon_clock = 1'b0;
    logic        reset = 1'b1;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [2:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [31:0] data_arith;
    logic        valid_arith;
    logic        ready_arith = 1'b0;
    logic        done_arith;

    int checks = 0;
    int errors = 0;

    dp_ram_tx #(.ID(2), .DEPTH_LOG2(11)) dut (
        .avalon_clock(avalon_clock),
        .reset(reset),
        .read(read),
        .write(write),
        .address(address),
        .writedata(writedata),
        .readdata(readdata),
        .data_arith(data_arith),
        .valid_arith(valid_arith),
        .ready_arith(ready_arith),
        .done_arith(done_arith)
    );

    always #5 avalon_clock = ~avalon_clock;

    task automatic tick();
        @(posedge avalon_clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        write = 1'b1;
        address = a;
        writedata = d;
        tick();
        write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        read = 1'b1;
        address = a;
        tick();
        read = 1'b0;
        v = readdata;
    endtask

    // Start with ready held high; expect e0..e3 on consecutive cycles.
    task automatic run_stream(input string tag, input logic [31:0] e0,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic [31:0] e3);
        logic [31:0] e [4];
        logic [31:0] v;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        ready_arith = 1'b1;
        wr(3'd4, 32'h1);
        chk({tag, "_v_cyc1"}, 32'(valid_arith), 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk({tag, "_valid"}, 32'(valid_arith), 32'h1);
            chk({tag, "_data"}, data_arith, e[k]);
        end
        tick();
        chk({tag, "_v_after"}, 32'(valid_arith), 32'h0);
        tick();
        tick();
        rd(3'd4, v);
        chk({tag, "_status"}, v, 32'h2);
        chk({tag, "_done_arith"}, 32'(done_arith), 32'h1);
    endtask

    initial begin
        logic [31:0] v;
        logic        stalled;
        logic [31:0] held;
        int          nx;

        #2;
        chk("rst_valid", 32'(valid_arith), 32'h0);
        chk("rst_data", data_arith, 32'h0);
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_done", 32'(done_arith), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        rd(3'd4, v);
        chk("rst_status", v, 32'h0);

        // wr_ptr load and auto-increment
        wr(3'd1, 32'd0);
        wr(3'd0, 32'h99);
        wr(3'd1, 32'd1);
        wr(3'd0, 32'hA);
        wr(3'd0, 32'hB);
        wr(3'd0, 32'hC);
        rd(3'd1, v);
        chk("wrptr_4", v, 32'd4);
        wr(3'd2, 32'd4);
        rd(3'd2, v);
        chk("count_4", v, 32'd4);
        run_stream("ram_abc", 32'h99, 32'hA, 32'hB, 32'hC);

        // full-rate stream
        wr(3'd1, 32'd0);
        for (int i = 0; i < 4; i++)
            wr(3'd0, 32'h10 + 32'(i));
        run_stream("full", 32'h10, 32'h11, 32'h12, 32'h13);

        // back-pressure with ready pattern 1,0,0
        ready_arith = 1'b0;
        wr(3'd4, 32'h1);
        stalled = 1'b0;
        held = '0;
        nx = 0;
        for (int i = 0; i < 24; i++) begin
            ready_arith = (i % 3 == 0);
            if (stalled) begin
                chk("stall_valid", 32'(valid_arith), 32'h1);
                chk("stall_hold", data_arith, held);
            end
            stalled = valid_arith && !ready_arith;
            held = data_arith;
            if (valid_arith && ready_arith) begin
                chk("tog_data", data_arith, 32'h10 + 32'(nx));
                nx++;
            end
            tick();
        end
        chk("tog_count", 32'(nx), 32'd4);
        ready_arith = 1'b1;
        rd(3'd4, v);
        chk("tog_status", v, 32'h2);

        // count = 0: one busy cycle, no data
        wr(3'd2, 32'd0);
        wr(3'd4, 32'h1);
        chk("c0_valid1", 32'(valid_arith), 32'h0);
        rd(3'd4, v);
        chk("c0_busy", v, 32'h1);
        rd(3'd4, v);
        chk("c0_done", v, 32'h2);
        chk("c0_valid2", 32'(valid_arith), 32'h0);
        wr(3'd2, 32'd5000);
        rd(3'd2, v);
        chk("count_sat", v, 32'd2048);
        wr(3'd2, 32'd2047);
        rd(3'd2, v);
        chk("count_2047", v, 32'd2047);

        // write while busy is dropped and flagged
        wr(3'd2, 32'd4);
        wr(3'd1, 32'd8);
        ready_arith = 1'b0;
        wr(3'd4, 32'h1);
        wr(3'd0, 32'hDEAD);
        rd(3'd1, v);
        chk("busy_wrptr", v, 32'd8);
        rd(3'd4, v);
        chk("busy_status", v, 32'h5);
        ready_arith = 1'b1;
        for (int i = 0; i < 8; i++)
            tick();
        rd(3'd4, v);
        chk("err_done", v, 32'h6);
        wr(3'd4, 32'h2);
        rd(3'd4, v);
        chk("err_clear", v, 32'h0);

        // reset mid-stream after two transfers
        rd(3'd3, v);
        chk("id_pre", v, 32'd2);
        wr(3'd4, 32'h1);
        tick();
        tick();
        tick();
        chk("mid_data", data_arith, 32'h12);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(valid_arith), 32'h0);
        chk("mid_rst_data", data_arith, 32'h0);
        chk("mid_rst_done", 32'(done_arith), 32'h0);
        chk("mid_rst_rdata", readdata, 32'h0);
        #2;
        reset = 1'b0;
        tick();
        rd(3'd4, v);
        chk("mid_status", v, 32'h0);
        rd(3'd3, v);
        chk("id", v, 32'd2);
        rd(3'd1, v);
        chk("rst_wrptr", v, 32'd0);
        chk("no_restart", 32'(valid_arith), 32'h0);
        wr(3'd1, 32'd2047);
        wr(3'd0, 32'h1);
        wr(3'd0, 32'h2);
        rd(3'd1, v);
        chk("wrap", v, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dp_ram_tx.md
DP_RAM_TX -- requirements
Module: dp_ram_tx

Interface
REQ-001 SHALL have parameter ID, default 2, meaning the constant returned on Avalon read of address 3.
REQ-002 SHALL have parameter DEPTH_LOG2, default 11, meaning the RAM address width; depth is 2**DEPTH_LOG2 words of 32 bits.
REQ-003 SHALL have ports: avalon_clock in 1 (sole clock; all logic on its rising edge); reset in 1 (asynchronous, active-high).
REQ-004 SHALL have Avalon slave ports: read in 1; write in 1; address in 3; writedata in 32; readdata out 32 (registered).
REQ-005 SHALL have stream ports: data_arith out 32; valid_arith out 1; ready_arith in 1 (consumer accept); done_arith out 1 (level, stream complete).

Function
REQ-006 SHALL implement a 2**DEPTH_LOG2 x 32 RAM: HPS-side write port; stream-side read port with 1-cycle registered read latency.
REQ-007 SHALL, on write to address 0 while not busy, store writedata at ram[wr_ptr] and increment wr_ptr by 1 per write cycle, wrapping 2047->0.
REQ-008 SHALL, on write to address 0 while busy, drop the data, leave wr_ptr unchanged and set sticky status bit2 (wr_err).
REQ-009 SHALL load wr_ptr from writedata[10:0] on write to address 1; reads of address 1 SHALL return {21'b0, wr_ptr}.
REQ-010 SHALL load the 12-bit count register on write to address 2; values >2048 saturate to 2048; reads return {20'b0, count}.
REQ-011 SHALL treat write to address 4 as control: bit0=1 starts a stream if idle (ignored if busy); bit1=1 clears done and wr_err.
REQ-012 SHALL return on read of address 3 the value ID; of address 4 {29'b0, wr_err, done, busy}; other addresses 0; readdata updates 1 cycle after read.
REQ-013 SHALL process read and write in the same cycle independently; wr_ptr write (address 1) takes priority over the address-0 increment.
REQ-014 SHALL use FSM states IDLE, PRIME, STREAM, FINISH: IDLE->PRIME on start with count>0; IDLE->FINISH on start with count=0; PRIME->STREAM after first RAM read returns; STREAM->FINISH when word count-1 transfers; FINISH->IDLE next cycle.
REQ-015 SHALL assert busy in PRIME, STREAM and FINISH; done SHALL set on entry to IDLE from FINISH and hold until cleared or a new start.
REQ-016 SHALL deliver words ram[0]..ram[count-1] in order, independent of wr_ptr.
REQ-017 SHALL define a transfer as valid_arith & ready_arith on a rising edge; data_arith SHALL hold stable while valid_arith & ~ready_arith.
REQ-018 SHALL assert first valid_arith exactly 2 cycles after the start write cycle.
REQ-019 SHALL, with ready_arith held high, transfer one word per cycle with no bubbles (prefetch buffer of at least 2 words).
REQ-020 SHALL deassert valid_arith in the cycle after the last transfer; done_arith mirrors status done.
REQ-021 SHALL never emit more than count words nor repeat a word under any ready_arith pattern.

Reset
REQ-022 SHALL, on reset assertion at any time including mid-stream, immediately force: state IDLE, wr_ptr=0, count=0, done=0, wr_err=0, busy=0, valid_arith=0, data_arith=0, readdata=0, done_arith=0.
REQ-023 SHALL leave RAM contents unaffected by reset; after deassertion, a stream start SHALL require a fresh control write.

Verification
REQ-024 Write 1 to addr 1, then 0xA, 0xB, 0xC to addr 0; read addr 1 -> 4; RAM[1..3] = 0xA, 0xB, 0xC.
REQ-025 Load RAM[0..3]=0x10..0x13, count=4, start, ready_arith=1 -> valid 2 cycles after start, 0x10..0x13 on 4 consecutive cycles, then valid=0, status=0x2.
REQ-026 Same load, ready_arith toggling 1,0,0,1,... -> same 4 words in order, data stable while stalled, exactly 4 transfers.
REQ-027 count=0, start -> no valid_arith; status goes busy for 1 cycle then 0x2; write count=5000 -> reads back 2048.
REQ-028 Write addr 0 during streaming -> data dropped, wr_ptr unchanged, status bit2=1; control write 0x2 -> status 0x0.
REQ-029 Assert reset mid-stream after 2 transfers -> valid_arith=0 and status 0x0 same cycle; read addr 3 -> ID; wr_ptr write 2047 then two addr-0 writes -> wr_ptr reads 1.
